// File: rtl/helio_pkg.sv
// Shared definitions for the lamp PWM generator and the PWM capture block.
// Holds the default counter width, duty scale and capture FSM encodings.
package helio_pkg;

  localparam int CNT_W_DEFAULT = 28;
  localparam int DUTY_MAX      = 100;
  localparam int DUTY_W        = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } cap_state_e;

endpackage

// File: rtl/pwm_div_serial.sv
// Serial restoring divider producing one quotient bit per cycle.
// Only the low DUTY_W quotient bits are kept since the caller guarantees a quotient <= 100.
module pwm_div_serial
  import helio_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEFAULT,
  parameter int PROD_W = CNT_W + 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PROD_W-1:0] dividend,
  input  logic [CNT_W-1:0]  divisor,
  output logic              busy,
  output logic              done,
  output logic [DUTY_W-1:0] quotient
);

  localparam int STEP_W = $clog2(PROD_W);

  logic [STEP_W-1:0] step_q;
  logic [CNT_W-1:0]  rem_q;
  logic [CNT_W-1:0]  dvs_q;
  logic [PROD_W-1:0] dvd_q;
  logic [DUTY_W-2:0] quo_q;
  logic [CNT_W:0]    shifted;
  logic [CNT_W-1:0]  rem_trial;
  logic [CNT_W-1:0]  rem_next;
  logic              fits;

  // The shifted-out remainder MSB means the partial remainder already exceeds any divisor,
  // and the modulo subtraction still lands on the correct (smaller than divisor) value.
  always_comb begin
    shifted   = {rem_q, dvd_q[PROD_W-1]};
    rem_trial = shifted[CNT_W-1:0] - dvs_q;
    fits      = shifted[CNT_W] | (shifted[CNT_W-1:0] >= dvs_q);
    rem_next  = fits ? rem_trial : shifted[CNT_W-1:0];
  end

  // done marks the final step; the quotient is taken combinationally in that cycle.
  assign done     = busy && (step_q == STEP_W'(PROD_W - 1));
  assign quotient = {quo_q, fits};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      step_q <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      dvd_q  <= '0;
      quo_q  <= '0;
    end else if (start && (!busy || done)) begin
      busy   <= 1'b1;
      step_q <= '0;
      rem_q  <= '0;
      dvs_q  <= divisor;
      dvd_q  <= dividend;
      quo_q  <= '0;
    end else if (busy) begin
      rem_q  <= rem_next;
      dvd_q  <= {dvd_q[PROD_W-2:0], 1'b0};
      quo_q  <= {quo_q[DUTY_W-3:0], fits};
      step_q <= step_q + STEP_W'(1);
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: synchronizes an asynchronous PWM pin and reports high time, period and duty.
// A level watchdog reports 0 % / 100 % when the pin stops toggling.
module pwm_capture
  import helio_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int TIMEOUT     = 1_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  high_cycles,
  output logic [CNT_W-1:0]  period_cycles,
  output logic [DUTY_W-1:0] duty_pct,
  output logic              meas_valid,
  output logic              stuck,
  output logic              overrun
);

  localparam int PROD_W = CNT_W + 7;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pin_s;
  logic                   pin_prev;
  logic                   rise;
  logic                   fall;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q   <= '0;
      pin_prev <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      pin_prev <= pin_s;
    end
  end

  assign pin_s = sync_q[SYNC_STAGES-1];
  assign rise  = pin_s & ~pin_prev;
  assign fall  = ~pin_s & pin_prev;

  logic [CNT_W-1:0] wd_q;
  logic             timeout;

  assign timeout = (wd_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wd_q <= '0;
    end else if (timeout || rise || fall) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + CNT_W'(1);
    end
  end

  cap_state_e state_q;
  cap_state_e state_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (rise) state_d = HIGH;
        HIGH:    if (fall) state_d = LOW;
        LOW:     if (rise) state_d = HIGH;
        default: state_d = IDLE;
      endcase
    end
  end

  logic load_cnt;
  logic inc_high;
  logic inc_period;
  logic close_period;

  // The falling-edge cycle already belongs to the low phase, so it only advances the period.
  always_comb begin
    load_cnt     = 1'b0;
    inc_high     = 1'b0;
    inc_period   = 1'b0;
    close_period = 1'b0;
    if (!timeout) begin
      case (state_q)
        IDLE: begin
          load_cnt = rise;
        end
        HIGH: begin
          inc_period = 1'b1;
          inc_high   = ~fall;
        end
        LOW: begin
          if (rise) begin
            close_period = 1'b1;
            load_cnt     = 1'b1;
          end else begin
            inc_period = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      high_cnt   <= '0;
      period_cnt <= '0;
    end else if (load_cnt) begin
      high_cnt   <= CNT_W'(1);
      period_cnt <= CNT_W'(1);
    end else begin
      if (inc_high && (high_cnt != '1)) begin
        high_cnt <= high_cnt + CNT_W'(1);
      end
      if (inc_period && (period_cnt != '1)) begin
        period_cnt <= period_cnt + CNT_W'(1);
      end
    end
  end

  logic              div_busy;
  logic              div_done;
  logic              div_start;
  logic              div_overrun;
  logic [DUTY_W-1:0] div_quotient;
  logic [PROD_W-1:0] div_dividend;

  // A divider finishing in the same cycle frees it for the period that is closing now.
  assign div_start    = close_period && (!div_busy || div_done);
  assign div_overrun  = close_period && div_busy && !div_done;
  assign div_dividend = PROD_W'(high_cnt) * PROD_W'(DUTY_MAX);

  pwm_div_serial #(
    .CNT_W  (CNT_W),
    .PROD_W (PROD_W)
  ) u_div (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (period_cnt),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  logic [CNT_W-1:0] pend_high;
  logic [CNT_W-1:0] pend_period;
  logic             discard_q;
  logic             use_result;

  assign use_result = div_done && !discard_q && !timeout;

  // A timeout invalidates whatever the divider is still working on.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pend_high   <= '0;
      pend_period <= '0;
      discard_q   <= 1'b0;
    end else begin
      if (div_start) begin
        pend_high   <= high_cnt;
        pend_period <= period_cnt;
      end
      if (timeout) begin
        discard_q <= div_busy && !div_done;
      end else if (div_start || div_done) begin
        discard_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      high_cycles   <= '0;
      period_cycles <= '0;
      duty_pct      <= '0;
      meas_valid    <= 1'b0;
      stuck         <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      overrun    <= div_overrun;
      meas_valid <= 1'b0;
      if (timeout) begin
        high_cycles   <= '0;
        period_cycles <= '0;
        duty_pct      <= pin_s ? DUTY_W'(DUTY_MAX) : '0;
        stuck         <= 1'b1;
        meas_valid    <= 1'b1;
      end else if (use_result) begin
        high_cycles   <= pend_high;
        period_cycles <= pend_period;
        duty_pct      <= div_quotient;
        stuck         <= 1'b0;
        meas_valid    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized bench for pwm_capture: drives glitch-free PWM and compares each report
// with a period-level model of what the capture block should measure.
module tb_pwm_capture;
  import helio_pkg::*;

  localparam int CNT_W       = 28;
  localparam int TIMEOUT     = 6000;
  localparam int SYNC_STAGES = 2;
  localparam int DIV_CYC     = CNT_W + 7;
  localparam int LAT         = SYNC_STAGES + CNT_W + 8;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              pwm_in = 1'b0;
  logic [CNT_W-1:0]  high_cycles;
  logic [CNT_W-1:0]  period_cycles;
  logic [DUTY_W-1:0] duty_pct;
  logic              meas_valid;
  logic              stuck;
  logic              overrun;

  pwm_capture #(
    .CNT_W       (CNT_W),
    .TIMEOUT     (TIMEOUT),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .pwm_in        (pwm_in),
    .high_cycles   (high_cycles),
    .period_cycles (period_cycles),
    .duty_pct      (duty_pct),
    .meas_valid    (meas_valid),
    .stuck         (stuck),
    .overrun       (overrun)
  );

  always #5 sys_clk = ~sys_clk;

  longint cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    longint hi;
    longint per;
    longint duty;
    bit     stk;
    longint at;
  } rep_t;

  rep_t   exp_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     obs_ovr = 0;
  int     exp_ovr = 0;
  bit     have_prev = 1'b0;
  longint prev_rise = 0;
  longint prev_high = 0;
  longint last_acc = -1000000;
  longint last_stuck_at = -1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // A rise ends the previous period; the divider takes it only if its last job is finished.
  task automatic closePeriod(input longint r);
    rep_t e;
    if (have_prev) begin
      e.hi   = prev_high;
      e.per  = r - prev_rise;
      e.duty = (prev_high * DUTY_MAX) / e.per;
      e.stk  = 1'b0;
      e.at   = r + LAT;
      if (r - last_acc >= DIV_CYC) begin
        exp_q.push_back(e);
        last_acc = r;
      end else begin
        exp_ovr++;
      end
    end
    have_prev = 1'b1;
    prev_rise = r;
  endtask

  // Called on a falling clock edge; drives one full high/low period.
  task automatic applyStimulus(input int h, input int l);
    pwm_in = 1'b1;
    closePeriod(cyc);
    prev_high = h;
    repeat (h) @(negedge sys_clk);
    pwm_in = 1'b0;
    repeat (l) @(negedge sys_clk);
  endtask

  task automatic holdStuck();
    rep_t e;
    pwm_in = 1'b1;
    closePeriod(cyc);
    e.hi = 0; e.per = 0; e.duty = DUTY_MAX; e.stk = 1'b1; e.at = -1;
    exp_q.push_back(e);
    exp_q.push_back(e);
    repeat (2 * TIMEOUT + 500) @(negedge sys_clk);
    have_prev = 1'b0;
    pwm_in = 1'b0;
    repeat (200) @(negedge sys_clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_high"}, high_cycles, 0);
    checkOutput({tag, "_period"}, period_cycles, 0);
    checkOutput({tag, "_duty"}, duty_pct, 0);
    checkOutput({tag, "_valid"}, meas_valid, 0);
    checkOutput({tag, "_stuck"}, stuck, 0);
    checkOutput({tag, "_overrun"}, overrun, 0);
  endtask

  // Every report is matched in order against the model's queue.
  always @(negedge sys_clk) begin
    rep_t e;
    if (sys_rst_n) begin
      if (overrun === 1'b1) obs_ovr++;
      if (meas_valid !== 1'b0) begin
        checkOutput("no_x", $isunknown({high_cycles, period_cycles, duty_pct, stuck}), 0);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_valid", meas_valid, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("high_cycles", high_cycles, e.hi);
          checkOutput("period_cycles", period_cycles, e.per);
          checkOutput("duty_pct", duty_pct, e.duty);
          checkOutput("stuck", stuck, e.stk);
          if (e.at >= 0) checkOutput("latency", cyc, e.at);
          if (e.stk) begin
            if (last_stuck_at >= 0) checkOutput("wd_interval", cyc - last_stuck_at, TIMEOUT);
            last_stuck_at = cyc;
          end else begin
            last_stuck_at = -1;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL sim_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int p;
    int d;
    int h;
    repeat (3) @(posedge sys_clk);
    #1;
    checkAllZero("reset");
    #1 sys_rst_n = 1'b1;
    @(negedge sys_clk);

    repeat (4) applyStimulus(250, 250);
    checkOutput("duty_250_250", duty_pct, 50);
    repeat (3) applyStimulus(1, 499);
    checkOutput("duty_1_499", duty_pct, 0);
    repeat (3) applyStimulus(495, 5);
    checkOutput("duty_495_5", duty_pct, 99);

    repeat (12) applyStimulus(5, 5);
    repeat (12) applyStimulus(4, 3);

    // Reset asserted between clock edges in the middle of a high phase.
    pwm_in = 1'b1;
    closePeriod(cyc);
    prev_high = 0;
    repeat (100) @(negedge sys_clk);
    checkOutput("pre_reset_high", high_cycles, 4);
    @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1 checkAllZero("async_reset");
    pwm_in = 1'b0;
    repeat (3) @(posedge sys_clk);
    #2 sys_rst_n = 1'b1;
    exp_q.delete();
    have_prev = 1'b0;
    last_acc = -1000000;
    last_stuck_at = -1;
    @(negedge sys_clk);

    for (int i = 0; i < 10; i++) begin
      p = $urandom_range(5000, 40);
      d = $urandom_range(100, 0);
      h = (p * d) / 100;
      if (h < 1) h = 1;
      if (h > p - 1) h = p - 1;
      applyStimulus(h, p - h);
    end

    holdStuck();
    checkOutput("stuck_level", stuck, 1);
    repeat (4) applyStimulus(300, 200);
    checkOutput("duty_after_stuck", duty_pct, 60);
    checkOutput("stuck_cleared", stuck, 0);

    repeat (100) @(negedge sys_clk);
    checkOutput("reports_drained", exp_q.size(), 0);
    checkOutput("overrun_count", obs_ovr, exp_ovr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform (feedback from the LED driver stage or an external dimmer/sensor) and reports high time, period and integer duty percentage. It is the receive-side counterpart of the lamp PWM generator: it sits on the `sys_clk` domain, samples an asynchronous PWM pin and hands registered measurements to the mode/control logic. A stuck-level watchdog reports 0 % or 100 % when no edges arrive.

## Interface
- `CNT_W`, 28: width of the high-time and period counters; counters saturate at 2^CNT_W−1.
- `TIMEOUT`, 1_000_000: cycles without a qualifying edge before a stuck report; must be < 2^CNT_W−1.
- `SYNC_STAGES`, 2: input synchronizer depth (≥2).
- `sys_clk` in 1: system clock.
- `sys_rst_n` in 1: reset; asynchronous assert, active-low.
- `pwm_in` in 1: asynchronous PWM input.
- `high_cycles` out CNT_W: synchronized high time of the last full period, in cycles.
- `period_cycles` out CNT_W: rising-to-rising period of the last full period, in cycles.
- `duty_pct` out 7: floor(high_cycles×100 / period_cycles), range 0..100.
- `meas_valid` out 1: one-cycle pulse when the three result outputs update.
- `stuck` out 1: level; 1 while the last report was a timeout report.
- `overrun` out 1: one-cycle pulse when a completed period is dropped because the divider is busy.

## Operation
- Input path: `SYNC_STAGES` flops, then one edge-detect flop; rise/fall are detected on the synchronized signal.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: wait for rise → HIGH; clear both counters to 1.
  - HIGH: increment high and period counters each cycle. On fall → LOW.
  - LOW: increment period counter. On rise → close the period, latch (high, period) into the divider and restart counters at 1 → HIGH.
- Divider: sub-block computes (high×100)/period by restoring division. It is busy for `CNT_W`+7 cycles, and its result is registered into the outputs together with the latched high and period.
- Divider busy at period close: drop that period's result, pulse `overrun`, and continue measuring. The divider is never restarted mid-operation.
- Watchdog: a counter clears on any rise or fall, in every state. On reaching `TIMEOUT`:
  - load `high_cycles` = 0 and `period_cycles` = 0.
  - set `duty_pct` to 100 if the synchronized input is high, else 0.
  - set `stuck` = 1, pulse `meas_valid`, go to IDLE, clear the watchdog.
  - While the input stays stuck, this repeats every `TIMEOUT` cycles.
  - A timeout takes priority over a coincident edge. It also takes priority over a pending divider result, which is discarded.
- `stuck` clears on the next divider-produced `meas_valid`.
- Arithmetic:
  - Product is `CNT_W`+7 bits wide.
  - Saturated counters are divided as-is.
  - high ≤ period always, so the quotient is ≤100.
- Outputs are registered and hold between updates.

## Timing
- Reset values: `high_cycles` = 0, `period_cycles` = 0, `duty_pct` = 0, `meas_valid` = 0, `stuck` = 0, `overrun` = 0. FSM = IDLE, synchronizer and edge flops = 0.
- Edge latency: a pin edge is seen by the FSM `SYNC_STAGES`+1 cycles later.
- Result latency: `meas_valid` asserts `CNT_W`+8 cycles after the FSM cycle that detects the closing rise (36 cycles at defaults).
- Minimum measurable high or low time is 1 cycle after synchronization. Pulses narrower than one clock may be missed.
- First rise after reset or IDLE produces no report; the first report follows the second rise.
- Reset deasserted mid-period: measurement restarts in IDLE; no partial result is emitted.
- Simultaneous period close and divider completion: the completing result is written to outputs, and the new period is accepted in the same cycle (no overrun).

## Structure
- Shared package `helio_pkg`:
  - FSM state encodings (IDLE/HIGH/LOW).
  - `DUTY_MAX` = 100.
  - Default `CNT_W`, also used by the lamp PWM generator.
- Sub-module `pwm_div_serial`:
  - Ports: start, dividend, divisor, busy, done, quotient.
  - Restoring, one quotient bit per cycle.
- Top level holds the synchronizer, FSM, counters, watchdog and output registers.

## Test plan
- High 250 / low 250 cycles, repeated → after second rise: `high_cycles` = 250, `period_cycles` = 500, `duty_pct` = 50, one `meas_valid` per period.
- High 1 / low 499 → `high_cycles` = 1, `period_cycles` = 500, `duty_pct` = 0 (floor). High 495 / low 5 → `duty_pct` = 99.
- `TIMEOUT` = 1000, pin held high → `meas_valid` every 1000 cycles, `duty_pct` = 100, `stuck` = 1, counts 0. Then 300/200 PWM → `stuck` clears, `duty_pct` = 60.
- High 5 / low 5 (period 10 < 35-cycle divider) → `overrun` pulses on periods closing while busy. Reported results are still `duty_pct` = 50, `period_cycles` = 10.
- `sys_rst_n` asserted mid-HIGH, asynchronously between clock edges → all outputs 0 immediately. No `meas_valid` before two further rises.
- Random glitch-free duty 0..100 % with periods 40..5000 → every `duty_pct` equals the floor model; no X on outputs after reset.
